// File: rtl/mem_access_mw_if.sv
// Data-memory port between the M stage (master) and the memory system (slave).
interface mem_access_mw_if;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [3:0]  dbe;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        dack;

  modport master (output dreq, dwe, daddr, dbe, dwdata, input drdata, dack);
  modport slave  (input dreq, dwe, daddr, dbe, dwdata, output drdata, dack);
endinterface

// File: rtl/mem_access_mw.sv
// MIPS-32 memory-access stage and MEM/WB register: bus handshake, lane
// alignment, load extension, misalignment and timeout reporting.
module mem_access_mw #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic        hilowriteM,
  input  logic [1:0]  MemSizeM,
  input  logic        MemSignedM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic [4:0]  writeregM,
  output logic        stallM,
  mem_access_mw_if.master mem,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        hilowriteW,
  output logic [31:0] aluoutW,
  output logic [31:0] readdataW,
  output logic [4:0]  writeregW,
  output logic        adelW,
  output logic        adesW,
  output logic        buserrW
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             squash_q;

  logic        memop, mis, start, timeout_hit, sq, ok;
  logic        sz_byte, sz_half;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_c;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign memop       = MemtoRegM | MemWriteM;
  assign sz_byte     = (MemSizeM == 2'b10);
  assign sz_half     = (MemSizeM == 2'b01);
  assign mis         = (sz_half & aluoutM[0]) |
                       (~sz_byte & ~sz_half & (aluoutM[1:0] != 2'b00));
  assign start       = (state_q == IDLE) & memop & ~mis & ~flush;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign sq          = squash_q | flush;
  assign ok          = mem.dack & ~sq;
  assign stallM      = (state_q == IDLE) ? start : (~mem.dack & ~timeout_hit);

  // Store lane enables / replicated data and load lane extraction.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = writedataM;
    if (sz_byte) begin
      be_c    = 4'b0001 << aluoutM[1:0];
      wdata_c = {4{writedataM[7:0]}};
    end else if (sz_half) begin
      be_c    = aluoutM[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{writedataM[15:0]}};
    end

    case (aluoutM[1:0])
      2'd0:    ld_byte = mem.drdata[7:0];
      2'd1:    ld_byte = mem.drdata[15:8];
      2'd2:    ld_byte = mem.drdata[23:16];
      default: ld_byte = mem.drdata[31:24];
    endcase
    ld_half = aluoutM[1] ? mem.drdata[31:16] : mem.drdata[15:0];

    load_c = mem.drdata;
    if (sz_byte)
      load_c = {{24{MemSignedM & ld_byte[7]}}, ld_byte};
    else if (sz_half)
      load_c = {{16{MemSignedM & ld_half[15]}}, ld_half};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      squash_q   <= 1'b0;
      mem.dreq   <= 1'b0;
      mem.dwe    <= 1'b0;
      mem.daddr  <= '0;
      mem.dbe    <= '0;
      mem.dwdata <= '0;
      RegWriteW  <= 1'b0;
      MemtoRegW  <= 1'b0;
      hilowriteW <= 1'b0;
      aluoutW    <= '0;
      readdataW  <= '0;
      writeregW  <= '0;
      adelW      <= 1'b0;
      adesW      <= 1'b0;
      buserrW    <= 1'b0;
    end else begin
      // Exception flags are single-cycle pulses.
      adelW   <= 1'b0;
      adesW   <= 1'b0;
      buserrW <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mem.dreq   <= 1'b1;
            mem.dwe    <= MemWriteM;
            mem.daddr  <= {aluoutM[31:2], 2'b00};
            mem.dbe    <= be_c;
            mem.dwdata <= wdata_c;
            cnt_q      <= '0;
            squash_q   <= 1'b0;
            state_q    <= BUSY;
          end else begin
            RegWriteW  <= RegWriteM  & ~flush & ~(memop & mis);
            MemtoRegW  <= MemtoRegM  & ~flush & ~(memop & mis);
            hilowriteW <= hilowriteM & ~flush & ~(memop & mis);
            aluoutW    <= aluoutM;
            writeregW  <= writeregM;
            readdataW  <= '0;
            adelW      <= ~flush & mis & MemtoRegM;
            adesW      <= ~flush & mis & MemWriteM & ~MemtoRegM;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (flush) squash_q <= 1'b1;
          // dack takes priority over a coincident timeout.
          if (mem.dack | timeout_hit) begin
            mem.dreq   <= 1'b0;
            squash_q   <= 1'b0;
            state_q    <= IDLE;
            RegWriteW  <= RegWriteM  & ok;
            MemtoRegW  <= MemtoRegM  & ok;
            hilowriteW <= hilowriteM & ok;
            aluoutW    <= aluoutM;
            writeregW  <= writeregM;
            readdataW  <= (ok & MemtoRegM) ? load_c : 32'd0;
            buserrW    <= ~mem.dack & ~sq;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_mw.sv
// Self-checking bench for mem_access_mw: vector table plus W-stage scoreboard.
module tb_mem_access_mw;
  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        RegWriteM, MemtoRegM, MemWriteM, hilowriteM, MemSignedM;
  logic [1:0]  MemSizeM;
  logic [31:0] aluoutM, writedataM;
  logic [4:0]  writeregM;
  logic        stallM;
  logic        RegWriteW, MemtoRegW, hilowriteW, adelW, adesW, buserrW;
  logic [31:0] aluoutW, readdataW;
  logic [4:0]  writeregW;

  mem_access_mw_if bus();

  mem_access_mw #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .hilowriteM(hilowriteM), .MemSizeM(MemSizeM), .MemSignedM(MemSignedM),
    .aluoutM(aluoutM), .writedataM(writedataM), .writeregM(writeregM),
    .stallM(stallM), .mem(bus.master),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .hilowriteW(hilowriteW),
    .aluoutW(aluoutW), .readdataW(readdataW), .writeregW(writeregW),
    .adelW(adelW), .adesW(adesW), .buserrW(buserrW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ld, st; logic [1:0] sz; logic sgn, rw, hilo;
    logic [31:0] addr, wd, rd; int dly;
    logic req; logic [3:0] dbe; logic [31:0] dwd;
    logic xrw, xmtr, xhilo; logic [31:0] xrd; logic adel, ades, berr;
  } vec_t;

  typedef struct {
    logic rw, mtr, hilo; logic [31:0] alu, rd; logic [4:0] wreg;
    logic adel, ades, berr;
  } wexp_t;

  int    checks = 0;
  int    failures = 0;
  wexp_t sb[$];
  vec_t  tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(logic ld, logic st, logic [1:0] sz, logic sgn, logic rw,
                              logic hilo, logic [31:0] addr, logic [31:0] wd,
                              logic [31:0] rd, int dly, logic req, logic [3:0] dbe,
                              logic [31:0] dwd, logic xrw, logic xmtr, logic xhilo,
                              logic [31:0] xrd, logic adel, logic ades, logic berr);
    vec_t v;
    v.ld = ld; v.st = st; v.sz = sz; v.sgn = sgn; v.rw = rw; v.hilo = hilo;
    v.addr = addr; v.wd = wd; v.rd = rd; v.dly = dly; v.req = req; v.dbe = dbe;
    v.dwd = dwd; v.xrw = xrw; v.xmtr = xmtr; v.xhilo = xhilo; v.xrd = xrd;
    v.adel = adel; v.ades = ades; v.berr = berr;
    return v;
  endfunction

  task automatic drive_nop();
    flush = 0; RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0; hilowriteM = 0;
    MemSizeM = 0; MemSignedM = 0; aluoutM = 0; writedataM = 0; writeregM = 0;
    bus.dack = 0; bus.drdata = 0;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [1:0] sz,
                          input logic sgn, input logic rw, input logic hilo,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] wreg);
    MemtoRegM = ld; MemWriteM = st; MemSizeM = sz; MemSignedM = sgn;
    RegWriteM = rw; hilowriteM = hilo; aluoutM = addr; writedataM = wd;
    writeregM = wreg;
  endtask

  task automatic pop_check(input string nm);
    wexp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty actual=W-load required=expected-entry", nm);
      return;
    end
    checks--;
    e = sb.pop_front();
    chk({nm, ".RegWriteW"},  32'(RegWriteW),  32'(e.rw));
    chk({nm, ".MemtoRegW"},  32'(MemtoRegW),  32'(e.mtr));
    chk({nm, ".hilowriteW"}, 32'(hilowriteW), 32'(e.hilo));
    chk({nm, ".aluoutW"},    aluoutW,         e.alu);
    chk({nm, ".readdataW"},  readdataW,       e.rd);
    chk({nm, ".writeregW"},  32'(writeregW),  32'(e.wreg));
    chk({nm, ".adelW"},      32'(adelW),      32'(e.adel));
    chk({nm, ".adesW"},      32'(adesW),      32'(e.ades));
    chk({nm, ".buserrW"},    32'(buserrW),    32'(e.berr));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    wexp_t e;
    bit    done;
    string nm;
    nm = $sformatf("vec%0d", idx);
    drive_op(v.ld, v.st, v.sz, v.sgn, v.rw, v.hilo, v.addr, v.wd, 5'(idx + 1));
    e.rw = v.xrw; e.mtr = v.xmtr; e.hilo = v.xhilo; e.alu = v.addr; e.rd = v.xrd;
    e.wreg = 5'(idx + 1); e.adel = v.adel; e.ades = v.ades; e.berr = v.berr;
    sb.push_back(e);
    #1 chk({nm, ".stall_idle"}, 32'(stallM), 32'(v.req));
    tick();
    if (!v.req) begin
      chk({nm, ".dreq"}, 32'(bus.dreq), 32'd0);
      pop_check(nm);
    end else begin
      chk({nm, ".dreq"},   32'(bus.dreq), 32'd1);
      chk({nm, ".dwe"},    32'(bus.dwe),  32'(v.st));
      chk({nm, ".daddr"},  bus.daddr,     {v.addr[31:2], 2'b00});
      chk({nm, ".dbe"},    32'(bus.dbe),  32'(v.dbe));
      chk({nm, ".dwdata"}, bus.dwdata,    v.dwd);
      done = 0;
      for (int k = 0; k < int'(TMO) + 2 && !done; k++) begin
        if (k == v.dly) begin bus.dack = 1; bus.drdata = v.rd; end
        #1;
        chk({nm, ".busy_dreq"}, 32'(bus.dreq), 32'd1);
        chk({nm, ".busy_stall"}, 32'(stallM),
            32'(!(k == v.dly || k == int'(TMO) - 1)));
        if (!stallM) done = 1;
        tick();
        bus.dack = 0;
      end
      if (!done) begin
        failures++; checks++;
        $display("FAIL %s stall_bound actual=stuck required=release", nm);
        sb.delete();
      end else begin
        chk({nm, ".dreq_drop"}, 32'(bus.dreq), 32'd0);
        pop_check(nm);
      end
    end
    drive_nop();
  endtask

  initial begin
    drive_nop();
    reset = 0;
    tbl[0]  = mk(1,0,2'd0,0,1,0,32'h100,0,32'hDEADBEEF,1, 1,4'hF,0, 1,1,0,32'hDEADBEEF,0,0,0);
    tbl[1]  = mk(1,0,2'd2,1,1,0,32'h103,0,32'h80112233,0, 1,4'h8,0, 1,1,0,32'hFFFFFF80,0,0,0);
    tbl[2]  = mk(1,0,2'd2,0,1,0,32'h103,0,32'h80112233,0, 1,4'h8,0, 1,1,0,32'h00000080,0,0,0);
    tbl[3]  = mk(0,1,2'd1,0,0,0,32'h202,32'h0000ABCD,0,0, 1,4'hC,32'hABCDABCD, 0,0,0,0,0,0,0);
    tbl[4]  = mk(1,0,2'd0,0,1,0,32'h101,0,0,0, 0,4'h0,0, 0,0,0,0,1,0,0);
    tbl[5]  = mk(0,1,2'd1,0,0,0,32'h203,32'h1234,0,0, 0,4'h0,0, 0,0,0,0,0,1,0);
    tbl[6]  = mk(0,1,2'd2,0,0,0,32'h201,32'h0000005A,0,2, 1,4'h2,32'h5A5A5A5A, 0,0,0,0,0,0,0);
    tbl[7]  = mk(1,0,2'd1,1,1,0,32'h206,0,32'h80011234,1, 1,4'hC,0, 1,1,0,32'hFFFF8001,0,0,0);
    tbl[8]  = mk(1,0,2'd1,0,1,0,32'h204,0,32'h1234F00D,0, 1,4'h3,0, 1,1,0,32'h0000F00D,0,0,0);
    tbl[9]  = mk(0,0,2'd0,0,1,1,32'h12345678,0,0,0, 0,4'h0,0, 1,0,1,0,0,0,0);
    tbl[10] = mk(1,0,2'd0,0,1,0,32'h300,0,0,255, 1,4'hF,0, 0,0,0,0,0,0,1);
    tbl[11] = mk(1,0,2'd3,1,1,0,32'h10C,0,32'hCAFEF00D,0, 1,4'hF,0, 1,1,0,32'hCAFEF00D,0,0,0);
    tbl[12] = mk(1,0,2'd2,1,1,0,32'h101,0,32'h00007F00,0, 1,4'h2,0, 1,1,0,32'h0000007F,0,0,0);
    tbl[13] = mk(1,0,2'd0,0,1,0,32'h110,0,32'h11223344,3, 1,4'hF,0, 1,1,0,32'h11223344,0,0,0);

    repeat (3) tick();
    chk("rst.dreq",      32'(bus.dreq),  32'd0);
    chk("rst.dbe",       32'(bus.dbe),   32'd0);
    chk("rst.RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rst.aluoutW",   aluoutW,        32'd0);
    chk("rst.readdataW", readdataW,      32'd0);
    chk("rst.stallM",    32'(stallM),    32'd0);
    reset = 1;
    tick();

    for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

    // Flush while IDLE: no request, clean bubble.
    drive_op(1,0,2'd0,0,1,0,32'h100,0,5'd3); flush = 1;
    #1 chk("flush_idle.stall", 32'(stallM), 32'd0);
    tick();
    chk("flush_idle.dreq",      32'(bus.dreq),  32'd0);
    chk("flush_idle.RegWriteW", 32'(RegWriteW), 32'd0);
    chk("flush_idle.MemtoRegW", 32'(MemtoRegW), 32'd0);
    chk("flush_idle.adelW",     32'(adelW),     32'd0);
    drive_nop();

    // Flag pulse clears during a following stall.
    drive_op(1,0,2'd0,0,1,0,32'h102,0,5'd4);
    tick();
    chk("pulse.adel_set", 32'(adelW), 32'd1);
    drive_op(1,0,2'd0,0,1,0,32'h100,0,5'd4);
    #1 chk("pulse.stall", 32'(stallM), 32'd1);
    tick();
    chk("pulse.adel_clr", 32'(adelW),     32'd0);
    chk("pulse.w_held",   32'(RegWriteW), 32'd0);
    bus.dack = 1; bus.drdata = 32'h0BADF00D;
    tick();
    bus.dack = 0;
    chk("pulse.readdataW", readdataW, 32'h0BADF00D);
    drive_nop();

    // Flush while BUSY: transaction finishes, W gets a flag-free bubble.
    drive_op(1,0,2'd0,0,1,0,32'h140,0,5'd9);
    tick();
    flush = 1;
    #1 chk("flush_busy.stall", 32'(stallM), 32'd1);
    tick();
    flush = 0;
    chk("flush_busy.dreq_held", 32'(bus.dreq), 32'd1);
    tick();
    bus.dack = 1; bus.drdata = 32'h55;
    #1 chk("flush_busy.stall_rel", 32'(stallM), 32'd0);
    tick();
    bus.dack = 0;
    chk("flush_busy.dreq",      32'(bus.dreq),  32'd0);
    chk("flush_busy.RegWriteW", 32'(RegWriteW), 32'd0);
    chk("flush_busy.MemtoRegW", 32'(MemtoRegW), 32'd0);
    chk("flush_busy.buserrW",   32'(buserrW),   32'd0);
    chk("flush_busy.readdataW", readdataW,      32'd0);
    drive_nop();

    // dack while IDLE is ignored.
    bus.dack = 1;
    #1 chk("idle_dack.stall", 32'(stallM), 32'd0);
    tick();
    chk("idle_dack.dreq", 32'(bus.dreq), 32'd0);
    bus.dack = 0;

    // Reset in the middle of a store.
    drive_op(0,0,2'd0,0,1,0,32'hAA,0,5'd2);
    tick();
    drive_op(0,1,2'd0,0,0,0,32'h208,32'h77,5'd0);
    tick();
    chk("rst_busy.dreq_pre", 32'(bus.dreq), 32'd1);
    reset = 0;
    tick();
    chk("rst_busy.dreq",      32'(bus.dreq),  32'd0);
    chk("rst_busy.dbe",       32'(bus.dbe),   32'd0);
    chk("rst_busy.daddr",     bus.daddr,      32'd0);
    chk("rst_busy.RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rst_busy.aluoutW",   aluoutW,        32'd0);
    drive_nop();
    reset = 1;
    #1 chk("rst_busy.idle", 32'(stallM), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
